// File: rtl/toast_pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// toast_pipeline_ctrl
//
// Hazard and control sequencer for a 5-stage in-order core. It decides when
// the front end must hold (load-use hazard, data memory wait, halt), when the
// front end must be squashed (taken branch, resume from halt), and when the
// back end must hold (data memory wait). It also keeps a saturating count of
// stall cycles for performance monitoring.
//
// Ports
//   clk_i              clock
//   reset_i            asynchronous active-high reset
//   IF_rs1_addr_i      rs1 field of the instruction entering ID
//   IF_rs2_addr_i      rs2 field of the instruction entering ID
//   ID_mem_rd_en_i     instruction in the ID->EX register is a load
//   ID_rd_addr_i       rd of the instruction in the ID->EX register
//   ID_exception_i     ECALL/EBREAK in the ID->EX register
//   EX_branch_taken_i  taken branch or jump resolved in EX
//   MEM_req_i          data memory access active in MEM
//   MEM_ready_i        data memory access completes this cycle
//   resume_i           debug resume pulse
//   clr_cnt_i          synchronous clear of the stall counter
//   stall_o            hold PC, IF->ID and ID->EX (combinational)
//   flush_o            squash IF->ID and ID->EX (combinational)
//   mem_stall_o        hold EX->MEM and MEM->WB (combinational)
//   halt_o             core halted on exception (registered)
//   state_o            current FSM state (registered)
//   stall_cnt_o        saturating count of cycles with stall_o=1 (registered)
// -----------------------------------------------------------------------------
module toast_pipeline_ctrl #(
    parameter int REGFILE_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH          = 16
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic [REGFILE_ADDR_WIDTH-1:0] IF_rs1_addr_i,
    input  logic [REGFILE_ADDR_WIDTH-1:0] IF_rs2_addr_i,
    input  logic                          ID_mem_rd_en_i,
    input  logic [REGFILE_ADDR_WIDTH-1:0] ID_rd_addr_i,
    input  logic                          ID_exception_i,
    input  logic                          EX_branch_taken_i,
    input  logic                          MEM_req_i,
    input  logic                          MEM_ready_i,
    input  logic                          resume_i,
    input  logic                          clr_cnt_i,
    output logic                          stall_o,
    output logic                          flush_o,
    output logic                          mem_stall_o,
    output logic                          halt_o,
    output logic [2:0]                    state_o,
    output logic [CNT_WIDTH-1:0]          stall_cnt_o
);

    typedef enum logic [2:0] {
        RUN      = 3'd0,
        MEM_WAIT = 3'd1,
        FLUSH    = 3'd2,
        HALT     = 3'd3
    } state_t;

    localparam logic [REGFILE_ADDR_WIDTH-1:0] REG_ZERO = {REGFILE_ADDR_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0]          CNT_MAX  = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0]          CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                 state_r;
    state_t                 next_state_s;
    logic                   halt_r;
    logic [CNT_WIDTH-1:0]   stall_cnt_r;
    logic                   stall_s;
    logic                   flush_s;
    logic                   mem_stall_s;
    logic                   load_use_s;
    logic                   mem_busy_s;

    // Hazard detection: load result needed by the very next instruction (x0 never hazards)
    always_comb begin
        load_use_s = ID_mem_rd_en_i & (ID_rd_addr_i != REG_ZERO) &
                     ((ID_rd_addr_i == IF_rs1_addr_i) | (ID_rd_addr_i == IF_rs2_addr_i));
        mem_busy_s = MEM_req_i & ~MEM_ready_i;
    end

    // Next-state and combinational pipeline-control outputs
    always_comb begin
        next_state_s = state_r;
        stall_s      = 1'b0;
        flush_s      = 1'b0;
        mem_stall_s  = 1'b0;
        if (reset_i) begin
            // Outputs must be quiet while reset is held, whatever the inputs do
            next_state_s = RUN;
        end else begin
            case (state_r)
                RUN: begin
                    if (mem_busy_s) begin
                        stall_s      = 1'b1;
                        mem_stall_s  = 1'b1;
                        next_state_s = MEM_WAIT;
                    end else if (EX_branch_taken_i) begin
                        // A coincident exception is on the wrong path and is dropped here
                        flush_s      = 1'b1;
                        next_state_s = FLUSH;
                    end else if (ID_exception_i) begin
                        next_state_s = HALT;
                    end else if (load_use_s) begin
                        stall_s      = 1'b1;
                        next_state_s = RUN;
                    end else begin
                        next_state_s = RUN;
                    end
                end
                MEM_WAIT: begin
                    if (MEM_ready_i) begin
                        // Access completes now, so both pipeline halves may advance
                        next_state_s = RUN;
                    end else begin
                        stall_s      = 1'b1;
                        mem_stall_s  = mem_busy_s;
                        next_state_s = MEM_WAIT;
                    end
                end
                FLUSH: begin
                    flush_s = 1'b1;
                    if (EX_branch_taken_i) begin
                        next_state_s = FLUSH;
                    end else begin
                        next_state_s = RUN;
                    end
                end
                HALT: begin
                    stall_s = 1'b1;
                    if (resume_i) begin
                        // Squash the halted instruction on the way out
                        next_state_s = FLUSH;
                    end else begin
                        next_state_s = HALT;
                    end
                end
                default: begin
                    next_state_s = RUN;
                end
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r <= RUN;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Halt flag register, aligned with entry to and exit from HALT
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            halt_r <= 1'b0;
        end else begin
            halt_r <= (next_state_s == HALT);
        end
    end

    // Saturating stall-cycle counter; clear has priority over counting
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            stall_cnt_r <= {CNT_WIDTH{1'b0}};
        end else if (clr_cnt_i) begin
            stall_cnt_r <= {CNT_WIDTH{1'b0}};
        end else if (stall_s && (stall_cnt_r != CNT_MAX)) begin
            stall_cnt_r <= stall_cnt_r + CNT_ONE;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_o     = stall_s;
    assign flush_o     = flush_s;
    assign mem_stall_o = mem_stall_s;
    assign halt_o      = halt_r;
    assign state_o     = state_r;
    assign stall_cnt_o = stall_cnt_r;

endmodule
